// File: rtl/keypad_record_playback.sv
// -----------------------------------------------------------------------------
// keypad_record_playback
//
// Records keypad digits into a small internal RAM during a timed window, waits
// for a hold interval, then replays the stored digits one per timebase tick.
// The timebase tick is derived from the system clock by an internal divider.
//
// Ports:
//   clock50MHz        system clock, rising edge
//   reset             synchronous, active-low
//   start             level; only looked at in IDLE
//   dav               keypad data-available (already synchronised)
//   KeypadData        digit, valid while dav=1
//   DataOut           replayed digit (0 outside PLAY)
//   DataValid         DataOut is meaningful
//   AddressOut        read pointer in PLAY, write pointer otherwise
//   Count             number of stored entries (0..DEPTH)
//   Full              Count == DEPTH
//   PresentStateFlag  IDLE=0, RECORD=1, HOLD=2, PLAY=3
//
// Handshake: there is no back-pressure on either side. An input digit is
// accepted on the rising edge of dav (dav=1 now, dav=0 the cycle before), so a
// dav held high stores once. On the output side DataOut carries a digit only
// in cycles where DataValid=1; the consumer has no ready and must sample then.
// -----------------------------------------------------------------------------
module keypad_record_playback #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int TICK_DIV     = 50000000,
    parameter int RECORD_TICKS = 8,
    parameter int HOLD_TICKS   = 3,
    parameter int LOOP         = 0
) (
    input  logic                  clock50MHz,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dav,
    input  logic [DATA_WIDTH-1:0] KeypadData,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic [ADDR_WIDTH-1:0] AddressOut,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Full,
    output logic [1:0]            PresentStateFlag
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TC_MAX = (RECORD_TICKS > HOLD_TICKS) ? RECORD_TICKS : HOLD_TICKS;
    // The tick counter never holds TC_MAX: the final tick of a phase changes state,
    // and every state change clears the counter.
    localparam int TC_W   = (TC_MAX > 1) ? $clog2(TC_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_HOLD   = 2'd2,
        ST_PLAY   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [TC_W-1:0]       tcnt_q, tcnt_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  dav_q;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;

    logic tick;
    logic dav_rise;
    logic full;
    logic last;

    always_comb begin
        tick     = (div_q == DIV_W'(TICK_DIV - 1));
        dav_rise = dav && !dav_q;
        full     = (count_q == (ADDR_WIDTH + 1)'(DEPTH));
        last     = ({1'b0, rptr_q} == count_q - 1'b1);
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tcnt_d     = tcnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        mem_we     = 1'b0;
        data_out_d = '0;
        valid_d    = 1'b0;

        if (state_q != ST_IDLE) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        if (tick && (state_q == ST_RECORD || state_q == ST_HOLD)) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RECORD;
                    wptr_d  = '0;
                    count_d = '0;
                end
            end
            ST_RECORD: begin
                if (dav_rise && !full) begin
                    mem_we  = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                end
                // Full is the registered count, so this leaves one cycle after the
                // last slot was filled. The timeout uses count_d so that a digit
                // captured on the timeout tick still counts toward the decision.
                if (full) begin
                    state_d = ST_HOLD;
                end else if (tick && tcnt_q == TC_W'(RECORD_TICKS - 1)) begin
                    state_d = (count_d == '0) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick && tcnt_q == TC_W'(HOLD_TICKS - 1)) begin
                    state_d = ST_PLAY;
                    rptr_d  = '0;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (!last) begin
                        rptr_d = rptr_q + 1'b1;
                    end else if (LOOP != 0) begin
                        rptr_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every phase is timed from its own entry.
        if (state_d != state_q) begin
            div_d  = '0;
            tcnt_d = '0;
        end

        // Synchronous RAM read at the next pointer. Gated on staying in PLAY so
        // the first PLAY cycle and the cycle after leaving both show 0/invalid.
        if (state_q == ST_PLAY && state_d == ST_PLAY) begin
            data_out_d = mem[rptr_d];
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clock50MHz) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            tcnt_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            dav_q      <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tcnt_q     <= tcnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            dav_q      <= dav;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    // RAM contents survive reset; Count=0 makes them unreachable.
    always_ff @(posedge clock50MHz) begin
        if (reset && mem_we) begin
            mem[wptr_q] <= KeypadData;
        end
    end

    assign DataOut          = data_out_q;
    assign DataValid        = valid_q;
    assign Count            = count_q;
    assign Full             = full;
    assign AddressOut       = (state_q == ST_PLAY) ? rptr_q : wptr_q;
    assign PresentStateFlag = state_q;

endmodule

// File: tb/tb_keypad_record_playback.sv
module tb_keypad_record_playback;

    localparam int DW       = 4;
    localparam int AW       = 2;
    localparam int DEPTH    = 1 << AW;
    localparam int TDIV     = 4;
    localparam int RT       = 3;
    localparam int HT       = 2;
    localparam int REC_CYC  = TDIV * RT;
    localparam int HOLD_CYC = TDIV * HT;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          dav   = 1'b0;
    logic [DW-1:0] kd    = '0;

    logic [DW-1:0] d0_out, d1_out;
    logic          d0_valid, d1_valid;
    logic [AW-1:0] d0_addr, d1_addr;
    logic [AW:0]   d0_count, d1_count;
    logic          d0_full, d1_full;
    logic [1:0]    d0_state, d1_state;

    keypad_record_playback #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TICK_DIV(TDIV),
        .RECORD_TICKS(RT), .HOLD_TICKS(HT), .LOOP(0)
    ) dut0 (
        .clock50MHz(clk), .reset(reset), .start(start), .dav(dav), .KeypadData(kd),
        .DataOut(d0_out), .DataValid(d0_valid), .AddressOut(d0_addr),
        .Count(d0_count), .Full(d0_full), .PresentStateFlag(d0_state)
    );

    keypad_record_playback #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TICK_DIV(TDIV),
        .RECORD_TICKS(RT), .HOLD_TICKS(HT), .LOOP(1)
    ) dut1 (
        .clock50MHz(clk), .reset(reset), .start(start), .dav(dav), .KeypadData(kd),
        .DataOut(d1_out), .DataValid(d1_valid), .AddressOut(d1_addr),
        .Count(d1_count), .Full(d1_full), .PresentStateFlag(d1_state)
    );

    // Observed outputs come from the looping instance only while use_loop is set.
    logic          use_loop = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic [AW-1:0] o_addr;
    logic [AW:0]   o_count;
    logic          o_full;
    logic [1:0]    o_state;
    assign o_data  = use_loop ? d1_out   : d0_out;
    assign o_valid = use_loop ? d1_valid : d0_valid;
    assign o_addr  = use_loop ? d1_addr  : d0_addr;
    assign o_count = use_loop ? d1_count : d0_count;
    assign o_full  = use_loop ? d1_full  : d0_full;
    assign o_state = use_loop ? d1_state : d0_state;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];   // digits expected in RAM, oldest first
    int            wr_cyc[$];  // RECORD cycle in which each expected digit was captured

    // Per-cycle dav/digit pattern applied during the recording window.
    bit            pat_dav [REC_CYC];
    logic [DW-1:0] pat_data[REC_CYC];

    function automatic string tg(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b0;
        start = 1'b0;
        dav   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", o_state, 0);
        chk("rst_count", o_count, 0);
        chk("rst_full",  o_full,  0);
        chk("rst_valid", o_valid, 0);
        chk("rst_data",  o_data,  0);
        chk("rst_addr",  o_addr,  0);
        reset = 1'b1;
    endtask

    task automatic clear_pat();
        for (int c = 0; c < REC_CYC; c++) begin
            pat_dav[c]  = 1'b0;
            pat_data[c] = DW'($urandom_range(0, (1 << DW) - 1));
        end
    endtask

    task automatic put(input int c, input int d);
        pat_dav[c]  = 1'b1;
        pat_data[c] = DW'(d);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference: a digit is captured on each low->high step of the pattern until
    // DEPTH digits are held; the window closes after REC_CYC cycles, or two cycles
    // after the capture that filled the RAM.
    task automatic do_record(output bit to_hold);
        int exit_c;
        bit prev;
        int n_before;
        exp_q.delete();
        wr_cyc.delete();
        exit_c = REC_CYC;
        prev   = 1'b0;
        for (int c = 0; c < REC_CYC; c++) begin
            if (pat_dav[c] && !prev) begin
                exp_q.push_back(pat_data[c]);
                wr_cyc.push_back(c);
                if (exp_q.size() == DEPTH) begin
                    exit_c = (c + 2 < REC_CYC) ? c + 2 : REC_CYC;
                    break;
                end
            end
            prev = pat_dav[c];
        end
        to_hold = (exp_q.size() != 0);

        for (int c = 0; c < exit_c; c++) begin
            n_before = 0;
            foreach (wr_cyc[i]) if (wr_cyc[i] < c) n_before++;
            chk(tg("rec_state", c), o_state, 1);
            chk(tg("rec_count", c), o_count, n_before);
            chk(tg("rec_full",  c), o_full,  (n_before == DEPTH));
            chk(tg("rec_addr",  c), o_addr,  n_before % DEPTH);
            chk(tg("rec_valid", c), o_valid, 0);
            chk(tg("rec_data",  c), o_data,  0);
            dav = pat_dav[c];
            kd  = pat_data[c];
            @(negedge clk);
        end
        chk("rec_exit_state", o_state, to_hold ? 2 : 0);
        chk("rec_exit_count", o_count, exp_q.size());
        chk("rec_exit_full",  o_full,  (exp_q.size() == DEPTH));
        // Rest of the pattern keeps going into HOLD, where it must be ignored.
        if (exit_c < REC_CYC) begin
            dav = pat_dav[exit_c];
            kd  = pat_data[exit_c];
        end else begin
            dav = 1'b0;
        end
    endtask

    task automatic do_hold();
        int n;
        n = exp_q.size();
        for (int h = 0; h < HOLD_CYC; h++) begin
            chk(tg("hold_state", h), o_state, 2);
            chk(tg("hold_count", h), o_count, n);
            chk(tg("hold_addr",  h), o_addr,  n % DEPTH);
            chk(tg("hold_valid", h), o_valid, 0);
            chk(tg("hold_data",  h), o_data,  0);
            @(negedge clk);
            dav = 1'b0;
        end
        chk("hold_exit_state", o_state, 3);
    endtask

    // Entry i is on DataOut for PLAY cycles [i*TDIV, (i+1)*TDIV), except that
    // nothing is valid in the very first PLAY cycle.
    task automatic do_play();
        int n;
        n = exp_q.size();
        for (int k = 0; k < n * TDIV; k++) begin
            chk(tg("play_state", k), o_state, 3);
            chk(tg("play_valid", k), o_valid, (k >= 1));
            chk(tg("play_data",  k), o_data,  (k >= 1) ? exp_q[k / TDIV] : 0);
            chk(tg("play_addr",  k), o_addr,  k / TDIV);
            @(negedge clk);
        end
        chk("play_end_state", o_state, 0);
        chk("play_end_valid", o_valid, 0);
        chk("play_end_data",  o_data,  0);
        chk("play_end_count", o_count, n);
    endtask

    task automatic do_play_loop();
        int n;
        n = exp_q.size();
        for (int k = 0; k < 3 * n * TDIV + 3; k++) begin
            chk(tg("loop_state", k), o_state, 3);
            chk(tg("loop_valid", k), o_valid, (k >= 1));
            chk(tg("loop_data",  k), o_data,  (k >= 1) ? exp_q[(k / TDIV) % n] : 0);
            chk(tg("loop_addr",  k), o_addr,  (k / TDIV) % n);
            start = (k == 5 || k == 6);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic round(input bit loop_mode);
        bit to_hold;
        do_start();
        do_record(to_hold);
        if (to_hold) begin
            do_hold();
            if (loop_mode) do_play_loop();
            else do_play();
        end else begin
            for (int i = 0; i < 4; i++) begin
                chk(tg("idle_state", i), o_state, 0);
                chk(tg("idle_count", i), o_count, 0);
                chk(tg("idle_valid", i), o_valid, 0);
                @(negedge clk);
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit to_hold;
        int dens;

        @(negedge clk);
        apply_reset();
        chk("rst_loop_state", d1_state, 0);

        // Two digits, the second on the timeout tick.
        clear_pat(); put(2, 5); put(11, 9);
        round(1'b0);

        // dav held high for 10 cycles stores one digit.
        clear_pat();
        for (int c = 0; c < 10; c++) put(c, 3);
        round(1'b0);

        // Five edges into a 4-deep RAM; the fifth arrives in HOLD.
        clear_pat(); put(0, 1); put(2, 2); put(4, 3); put(6, 4); put(8, 7);
        round(1'b0);

        // Empty window goes back to IDLE.
        clear_pat();
        round(1'b0);

        // Random patterns, back to back, at varying densities.
        for (int r = 0; r < 6; r++) begin
            clear_pat();
            dens = $urandom_range(1, 4);
            for (int c = 0; c < REC_CYC; c++) pat_dav[c] = ($urandom_range(0, dens) == 0);
            round(1'b0);
        end

        // Reset in the middle of HOLD, then record one digit on the timeout tick.
        clear_pat();
        put(0, $urandom_range(0, 15)); put(2, $urandom_range(0, 15)); put(4, $urandom_range(0, 15));
        do_start();
        do_record(to_hold);
        dav = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_state", o_state, 2);
        apply_reset();
        clear_pat(); put(11, 2);
        round(1'b0);

        // Looping playback with start pressed during PLAY.
        apply_reset();
        use_loop = 1'b1;
        clear_pat(); put(1, 6); put(4, 8);
        round(1'b1);
        apply_reset();
        use_loop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
